// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: scan FSM encoding and event word layout.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_NEXT
  } scan_state_t;

  // Event word is {release, code}; the code sits in the low bits.
  localparam int EVT_CODE_LSB = 0;

  function automatic int evt_rel_bit(input int code_w);
    return EVT_CODE_LSB + code_w;
  endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Synchronous event FIFO with full/empty flags; a pop frees a slot for a
// same-cycle push even when full.
module keypad_evt_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot row strobes, column-serial sampling, per-key
// debounce over scan frames, and press/release events queued in a FIFO.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SETTLE     = 4,
  parameter int DEB_FRAMES = 3,
  parameter int FIFO_DEPTH = 8,
  localparam int CODE_W    = $clog2(ROWS*COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [COLS-1:0]      col_in,
  output logic [ROWS-1:0]      row_out,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic [CODE_W-1:0]    evt_code,
  output logic                 evt_release,
  output logic                 overflow,
  output logic [ROWS*COLS-1:0] keys_down
);

  // state     | meaning
  // ST_IDLE   | one cycle after reset, selects row 0
  // ST_DRIVE  | row strobe on, waiting SETTLE cycles for the column sync
  // ST_SAMPLE | row strobe on, one column debounced per cycle
  // ST_NEXT   | strobe off for one cycle, advance (wrap) the row index

  localparam int NKEYS   = ROWS*COLS;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int SW      = $clog2(SETTLE);
  localparam int DW      = $clog2(DEB_FRAMES+1);
  localparam int REL_BIT = evt_rel_bit(CODE_W);

  scan_state_t       state, state_nxt;
  logic [RW-1:0]     row_idx, row_nxt;
  logic [CW-1:0]     col_idx, col_nxt;
  logic [SW-1:0]     settle_cnt, settle_nxt;
  logic [COLS-1:0]   col_meta, col_sync;
  logic [DW-1:0]     deb_cnt [NKEYS];
  logic [DW-1:0]     deb_inc;
  logic [CODE_W-1:0] key;
  logic              raw, deb_diff, deb_hit, evt_pop;
  logic              fifo_full, fifo_empty;
  logic [CODE_W:0]   evt_word, fifo_head;

  assign key      = CODE_W'(row_idx) * CODE_W'(COLS) + CODE_W'(col_idx);
  assign raw      = col_sync[col_idx];
  assign deb_inc  = deb_cnt[key] + DW'(1);
  assign deb_diff = (state == ST_SAMPLE) && (raw != keys_down[key]);
  assign deb_hit  = deb_diff && (deb_inc == DW'(DEB_FRAMES));
  assign evt_word = {~raw, key};
  assign evt_pop  = evt_valid && evt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      row_idx    <= '0;
      col_idx    <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_nxt;
      row_idx    <= row_nxt;
      col_idx    <= col_nxt;
      settle_cnt <= settle_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    row_nxt    = row_idx;
    col_nxt    = col_idx;
    settle_nxt = settle_cnt;
    row_out    = '0;
    case (state)
      ST_IDLE: begin
        state_nxt  = ST_DRIVE;
        row_nxt    = '0;
        settle_nxt = SW'(SETTLE-1);
      end
      ST_DRIVE: begin
        row_out = ROWS'(1) << row_idx;
        if (settle_cnt == '0) begin
          state_nxt = ST_SAMPLE;
          col_nxt   = '0;
        end else begin
          settle_nxt = settle_cnt - SW'(1);
        end
      end
      ST_SAMPLE: begin
        row_out = ROWS'(1) << row_idx;
        if (col_idx == CW'(COLS-1)) state_nxt = ST_NEXT;
        else                        col_nxt   = col_idx + CW'(1);
      end
      ST_NEXT: begin
        state_nxt  = ST_DRIVE;
        settle_nxt = SW'(SETTLE-1);
        row_nxt    = (row_idx == RW'(ROWS-1)) ? '0 : row_idx + RW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Only the key under the current row/column can change in a given cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta  <= '0;
      col_sync  <= '0;
      keys_down <= '0;
      overflow  <= 1'b0;
      for (int i = 0; i < NKEYS; i++) deb_cnt[i] <= '0;
    end else begin
      col_meta <= col_in;
      col_sync <= col_meta;
      if (state == ST_SAMPLE) begin
        if (!deb_diff || deb_hit) deb_cnt[key] <= '0;
        else                      deb_cnt[key] <= deb_inc;
        if (deb_hit) keys_down[key] <= raw;
      end
      if (deb_hit && fifo_full && !evt_pop) overflow <= 1'b1;
    end
  end

  keypad_evt_fifo #(
    .WIDTH (CODE_W+1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (deb_hit),
    .push_data (evt_word),
    .pop       (evt_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head storage is not reset, so the event fields are masked while empty.
  assign evt_valid   = !fifo_empty;
  assign evt_code    = evt_valid ? fifo_head[EVT_CODE_LSB +: CODE_W] : '0;
  assign evt_release = evt_valid & fifo_head[REL_BIT];

endmodule
